// File: rtl/dmem_port_scheduler.sv
// Dual-issue load/store scheduler: FIFO store buffer with load forwarding,
// arbitrating two shared data-memory ports (loads first, idle ports drain stores).
module dmem_port_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid0,
    input  logic                       req_valid1,
    input  logic                       req_write0,
    input  logic                       req_write1,
    input  logic [31:0]                req_addr0,
    input  logic [31:0]                req_addr1,
    input  logic [31:0]                req_wdata0,
    input  logic [31:0]                req_wdata1,
    output logic                       req_ready,
    output logic [31:0]                ld_data0,
    output logic [31:0]                ld_data1,
    input  logic                       fence,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                mem_addr1,
    output logic [31:0]                mem_addr2,
    output logic                       mem_write1,
    output logic                       mem_write2,
    output logic [31:0]                mem_wdata1,
    output logic [31:0]                mem_wdata2,
    input  logic [31:0]                mem_rdata1,
    input  logic [31:0]                mem_rdata2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [31:0]      buf_addr [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [DEPTH-1:0] buf_vld, vld_next;
    logic [PTR_W-1:0] head, tail, head1, push1_idx, drain1_idx, drain2_idx;
    logic             ld0, ld1, st0, st1, drain1, drain2;
    logic [CNT_W-1:0] n_push, n_drain;
    logic             fwd0_hit, fwd1_hit;
    logic [31:0]      fwd0_data, fwd1_data;

    function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
        return a == b;
    endfunction

    assign req_ready = !fence && (count <= READY_MAX);
    assign empty     = (count == '0);

    always_comb begin
        ld0        = req_valid0 && req_ready && !req_write0;
        ld1        = req_valid1 && req_ready && !req_write1;
        st0        = req_valid0 && req_ready && req_write0;
        st1        = req_valid1 && req_ready && req_write1;
        head1      = head + PTR_W'(1);
        push1_idx  = st0 ? tail + PTR_W'(1) : tail;
        n_push     = CNT_W'(st0) + CNT_W'(st1);

        // Lower-numbered free port takes head so a dual drain keeps the older store on port1.
        drain1     = 1'b0;
        drain2     = 1'b0;
        drain1_idx = head;
        drain2_idx = head;
        if (!ld0) begin
            drain1 = buf_vld[head];
            if (!ld1) begin
                drain2     = buf_vld[head1];
                drain2_idx = head1;
            end
        end else if (!ld1) begin
            drain2 = buf_vld[head];
        end
        n_drain = CNT_W'(drain1) + CNT_W'(drain2);

        mem_write1 = drain1;
        mem_write2 = drain2;
        mem_addr1  = drain1 ? buf_addr[drain1_idx] : (ld0 ? req_addr0 : 32'd0);
        mem_addr2  = drain2 ? buf_addr[drain2_idx] : (ld1 ? req_addr1 : 32'd0);
        mem_wdata1 = drain1 ? buf_data[drain1_idx] : 32'd0;
        mem_wdata2 = drain2 ? buf_data[drain2_idx] : 32'd0;

        // Scan oldest to youngest so the last hit is the youngest matching store.
        fwd0_hit  = 1'b0;
        fwd1_hit  = 1'b0;
        fwd0_data = 32'd0;
        fwd1_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_vld[head + PTR_W'(i)] &&
                word_match(buf_addr[head + PTR_W'(i)][31:2], req_addr0[31:2])) begin
                fwd0_hit  = 1'b1;
                fwd0_data = buf_data[head + PTR_W'(i)];
            end
            if (buf_vld[head + PTR_W'(i)] &&
                word_match(buf_addr[head + PTR_W'(i)][31:2], req_addr1[31:2])) begin
                fwd1_hit  = 1'b1;
                fwd1_data = buf_data[head + PTR_W'(i)];
            end
        end

        ld_data0 = 32'd0;
        if (ld0)
            ld_data0 = fwd0_hit ? fwd0_data : mem_rdata1;
        ld_data1 = 32'd0;
        if (ld1) begin
            if (st0 && word_match(req_addr0[31:2], req_addr1[31:2]))
                ld_data1 = req_wdata0;
            else
                ld_data1 = fwd1_hit ? fwd1_data : mem_rdata2;
        end

        // Push and pop slots never coincide: pushes need two free entries.
        vld_next = buf_vld;
        if (drain1) vld_next[drain1_idx] = 1'b0;
        if (drain2) vld_next[drain2_idx] = 1'b0;
        if (st0)    vld_next[tail]       = 1'b1;
        if (st1)    vld_next[push1_idx]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            buf_vld <= '0;
        end else begin
            head    <= head + PTR_W'(n_drain);
            tail    <= tail + PTR_W'(n_push);
            count   <= count + n_push - n_drain;
            buf_vld <= vld_next;
        end
    end

    always_ff @(posedge clk) begin
        if (st0) begin
            buf_addr[tail] <= req_addr0;
            buf_data[tail] <= req_wdata0;
        end
        if (st1) begin
            buf_addr[push1_idx] <= req_addr1;
            buf_data[push1_idx] <= req_wdata1;
        end
    end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Directed bench for dmem_port_scheduler with a 64-word dual-port memory model
// (negedge write, port2 wins on same-address dual write).
module tb_dmem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid0, req_valid1, req_write0, req_write1;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic        req_ready;
    logic [31:0] ld_data0, ld_data1;
    logic        fence;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] mem_addr1, mem_addr2, mem_wdata1, mem_wdata2, mem_rdata1, mem_rdata2;
    logic        mem_write1, mem_write2;
    logic        mem_clear;
    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    dmem_port_scheduler #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_write0(req_write0), .req_write1(req_write1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .ld_data0(ld_data0), .ld_data1(ld_data1),
        .fence(fence), .empty(empty), .count(count),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_write1(mem_write1), .mem_write2(mem_write2),
        .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
    );

    assign mem_rdata1 = mem[mem_addr1[7:2]];
    assign mem_rdata2 = mem[mem_addr2[7:2]];

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC000_0000 | 32'(i);
        end else begin
            if (mem_write1) mem[mem_addr1[7:2]] <= mem_wdata1;
            if (mem_write2) mem[mem_addr2[7:2]] <= mem_wdata2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        req_valid0 = v0; req_write0 = w0; req_addr0 = a0; req_wdata0 = d0;
        req_valid1 = v1; req_write1 = w1; req_addr1 = a1; req_wdata1 = d1;
    endtask

    task automatic idle();
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    // Advance to just after the next rising edge; checks follow a #2 settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_clear = 1'b1; fence = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; mem_clear = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_wr1", 32'(mem_write1), 32'd0);
        chk("rst_wr2", 32'(mem_write2), 32'd0);
        chk("rst_ld0", ld_data0, 32'd0);

        // Dual store, then dual drain on the next idle cycle.
        step(); drive(1, 1, 32'h10, 32'hAAAA_0000, 1, 1, 32'h14, 32'hBBBB_0000); #2;
        chk("a_ready", 32'(req_ready), 32'd1);
        step(); idle(); #2;
        chk("b_count", 32'(count), 32'd2);
        chk("b_wr1", 32'(mem_write1), 32'd1);
        chk("b_addr1", mem_addr1, 32'h10);
        chk("b_wd1", mem_wdata1, 32'hAAAA_0000);
        chk("b_wr2", 32'(mem_write2), 32'd1);
        chk("b_addr2", mem_addr2, 32'h14);
        chk("b_wd2", mem_wdata2, 32'hBBBB_0000);
        step(); #2;
        chk("c_count", 32'(count), 32'd0);
        chk("c_empty", 32'(empty), 32'd1);
        chk("c_mem4", mem[4], 32'hAAAA_0000);
        chk("c_mem5", mem[5], 32'hBBBB_0000);

        // Buffered store forwards to both load slots; loads hold both ports.
        step(); drive(1, 1, 32'h20, 32'h1234, 0, 0, 32'd0, 32'd0); #2;
        step(); drive(1, 0, 32'h20, 32'd0, 1, 0, 32'h20, 32'd0); #2;
        chk("e_ld0", ld_data0, 32'h1234);
        chk("e_ld1", ld_data1, 32'h1234);
        chk("e_wr1", 32'(mem_write1), 32'd0);
        chk("e_wr2", 32'(mem_write2), 32'd0);
        chk("e_count", 32'(count), 32'd1);
        step(); idle(); #2;
        chk("f_count", 32'(count), 32'd1);
        chk("f_wr1", 32'(mem_write1), 32'd1);
        chk("f_addr1", mem_addr1, 32'h20);

        // Same-cycle slot0 store -> slot1 load forwards; the reverse does not.
        step(); drive(1, 1, 32'h30, 32'h55, 1, 0, 32'h30, 32'd0); #2;
        chk("g_ld1", ld_data1, 32'h55);
        chk("g_ld0", ld_data0, 32'd0);
        step(); drive(1, 0, 32'h34, 32'd0, 1, 1, 32'h34, 32'h99); #2;
        chk("h_ld0", ld_data0, 32'hC000_000D);
        chk("h_ld1", ld_data1, 32'd0);
        chk("h_wr1", 32'(mem_write1), 32'd0);
        chk("h_addr1", mem_addr1, 32'h34);
        chk("h_wr2", 32'(mem_write2), 32'd1);
        chk("h_addr2", mem_addr2, 32'h30);
        chk("h_wd2", mem_wdata2, 32'h55);
        step(); idle(); #2;
        chk("i_count", 32'(count), 32'd1);
        step(); #2;
        chk("j_count", 32'(count), 32'd0);
        chk("j_mem12", mem[12], 32'h55);
        chk("j_mem13", mem[13], 32'h99);

        // Dual loads stall draining; a further dual store drains the two oldest.
        step(); drive(1, 1, 32'h80, 32'h11, 1, 1, 32'h84, 32'h22); #2;
        for (int k = 0; k < 3; k++) begin
            step(); drive(1, 0, 32'h80, 32'd0, 1, 0, 32'h84, 32'd0); #2;
            chk("l_count", 32'(count), 32'd2);
            chk("l_ld0", ld_data0, 32'h11);
            chk("l_ld1", ld_data1, 32'h22);
            chk("l_wr1", 32'(mem_write1), 32'd0);
        end
        step(); drive(1, 1, 32'h88, 32'h33, 1, 1, 32'h8C, 32'h44); #2;
        chk("m_ready", 32'(req_ready), 32'd1);
        chk("m_addr1", mem_addr1, 32'h80);
        chk("m_addr2", mem_addr2, 32'h84);
        chk("m_wr2", 32'(mem_write2), 32'd1);
        step(); idle(); #2;
        chk("n_count", 32'(count), 32'd2);
        chk("n_addr1", mem_addr1, 32'h88);
        chk("n_wd2", mem_wdata2, 32'h44);
        step(); #2;
        chk("o_count", 32'(count), 32'd0);
        chk("o_mem33", mem[33], 32'h22);
        chk("o_mem35", mem[35], 32'h44);

        // Same-address pair: youngest forwards, port2 carries the younger store.
        step(); drive(1, 1, 32'h40, 32'd1, 1, 1, 32'h40, 32'd2); #2;
        step(); drive(1, 0, 32'h40, 32'd0, 1, 0, 32'h44, 32'd0); #2;
        chk("q0_ld0", ld_data0, 32'd2);
        chk("q0_ld1", ld_data1, 32'hC000_0011);
        step(); idle(); #2;
        chk("q_wd1", mem_wdata1, 32'd1);
        chk("q_wd2", mem_wdata2, 32'd2);
        chk("q_addr2", mem_addr2, 32'h40);
        step(); #2;
        chk("r_mem16", mem[16], 32'd2);

        // Fence blocks new requests while the buffer drains.
        step(); drive(1, 1, 32'h50, 32'hA, 1, 1, 32'h54, 32'hB); #2;
        step(); fence = 1'b1; drive(1, 1, 32'h58, 32'hC, 0, 0, 32'd0, 32'd0); #2;
        chk("t_ready", 32'(req_ready), 32'd0);
        chk("t_empty", 32'(empty), 32'd0);
        chk("t_wr1", 32'(mem_write1), 32'd1);
        chk("t_wr2", 32'(mem_write2), 32'd1);
        step(); #2;
        chk("u_empty", 32'(empty), 32'd1);
        chk("u_ready", 32'(req_ready), 32'd0);
        step(); fence = 1'b0; idle(); #2;
        chk("v_ready", 32'(req_ready), 32'd1);
        chk("v_mem20", mem[20], 32'hA);
        chk("v_mem21", mem[21], 32'hB);
        chk("v_mem22", mem[22], 32'hC000_0016);

        // Reset with stores buffered discards them before any write.
        step(); drive(1, 1, 32'h60, 32'hD, 1, 1, 32'h64, 32'hE); #2;
        step(); idle(); rst_n = 1'b0; #2;
        chk("w_count", 32'(count), 32'd0);
        chk("w_wr1", 32'(mem_write1), 32'd0);
        chk("w_wr2", 32'(mem_write2), 32'd0);
        step(); step(); rst_n = 1'b1; #2;
        chk("x_empty", 32'(empty), 32'd1);
        step(); #2;
        chk("y_wr1", 32'(mem_write1), 32'd0);
        chk("y_wr2", 32'(mem_write2), 32'd0);
        chk("y_mem24", mem[24], 32'hC000_0018);
        chk("y_mem25", mem[25], 32'hC000_0019);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
